// File: rtl/serial_divider_if.sv
// Operation encoding and the issue/writeback interface of the serial divider.
// The package holds the functional-unit operation encoding shared by the issue
// stage and the divider. The interface bundles the request and result handshakes.
// The master modport is the issue/writeback side and the slave modport is the divider.

package serial_divider_pkg;

  typedef enum logic [3:0] {
    ADD,
    MUL,
    MULH,
    DIV,
    DIVU,
    REM,
    REMU,
    DIVW,
    DIVUW,
    REMW,
    REMUW
  } fu_op;

endpackage

interface serial_divider_if
  import serial_divider_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int TRANS_ID_BITS = 3
);

  logic                     flush_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     div_valid_i;
  fu_op                     operator_i;
  logic [WIDTH-1:0]         operand_a_i;
  logic [WIDTH-1:0]         operand_b_i;
  logic                     div_ready_o;
  logic                     div_valid_o;
  logic                     out_ready_i;
  logic [WIDTH-1:0]         result_o;
  logic [TRANS_ID_BITS-1:0] div_trans_id_o;

  modport master (
    output flush_i, trans_id_i, div_valid_i, operator_i, operand_a_i, operand_b_i,
           out_ready_i,
    input  div_ready_o, div_valid_o, result_o, div_trans_id_o
  );

  modport slave (
    input  flush_i, trans_id_i, div_valid_i, operator_i, operand_a_i, operand_b_i,
           out_ready_i,
    output div_ready_o, div_valid_o, result_o, div_trans_id_o
  );

endinterface

// File: rtl/serial_divider.sv
// Iterative radix-2 restoring divider for the RV64M divide group.
// The divider has one operation in flight and produces one quotient bit per cycle.
// Signed operations divide the operand magnitudes and apply the sign fix at the end.
// The optional macro SERIAL_DIVIDER_LZC_SKIP_EN adds a leading-zero skip.
// With the skip, the leading zero bits of |dividend| are not iterated over.

module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  serial_divider_if.slave   bus
);

  localparam int CNT_BITS = $clog2(WIDTH);
  localparam int W_BITS   = 32;

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e                   state_q;
  logic [CNT_BITS-1:0]      cnt_q;
  logic [WIDTH-1:0]         rem_q;
  logic [WIDTH-1:0]         quo_q;
  logic [WIDTH-1:0]         divisor_q;
  logic                     quo_op_q;
  logic                     w_op_q;
  logic                     quo_neg_q;
  logic                     rem_neg_q;
  logic                     div_zero_q;
  logic [TRANS_ID_BITS-1:0] trans_q;
  logic [WIDTH-1:0]         result_q;
  logic [TRANS_ID_BITS-1:0] trans_out_q;
  logic                     valid_q;
  logic                     ready_q;

  logic                     is_div_op;
  logic                     signed_op;
  logic                     w_op;
  logic                     quo_op;
  logic [WIDTH-1:0]         a_ext;
  logic [WIDTH-1:0]         b_ext;
  logic                     a_neg;
  logic                     b_neg;
  logic [WIDTH-1:0]         mag_a;
  logic [WIDTH-1:0]         mag_b;
  logic [CNT_BITS-1:0]      start_cnt;
  logic [WIDTH-1:0]         start_quo;

  logic [WIDTH:0]           rem_shift;
  logic                     rem_ge;
  logic [WIDTH-1:0]         rem_next;
  logic [WIDTH-1:0]         quo_next;
  logic [WIDTH-1:0]         quo_fix;
  logic [WIDTH-1:0]         rem_fix;
  logic [WIDTH-1:0]         res_sel;
  logic [WIDTH-1:0]         res_final;

  // Decode the operation into signedness, word size and quotient/remainder select.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    is_div_op = 1'b1;
    signed_op = 1'b0;
    w_op      = 1'b0;
    quo_op    = 1'b0;
    case (bus.operator_i)
      DIV:     begin signed_op = 1'b1; quo_op = 1'b1; end
      DIVU:    quo_op = 1'b1;
      REM:     signed_op = 1'b1;
      REMU:    ;
      DIVW:    begin signed_op = 1'b1; quo_op = 1'b1; w_op = 1'b1; end
      DIVUW:   begin quo_op = 1'b1; w_op = 1'b1; end
      REMW:    begin signed_op = 1'b1; w_op = 1'b1; end
      REMUW:   w_op = 1'b1;
      default: is_div_op = 1'b0;
    endcase
  end

  // Extend W-op operands and form the magnitudes and sign flags.
  always_comb begin
    a_ext = bus.operand_a_i;
    b_ext = bus.operand_b_i;
    if (w_op) begin
      a_ext = {{(WIDTH-W_BITS){signed_op & bus.operand_a_i[W_BITS-1]}}, bus.operand_a_i[W_BITS-1:0]};
      b_ext = {{(WIDTH-W_BITS){signed_op & bus.operand_b_i[W_BITS-1]}}, bus.operand_b_i[W_BITS-1:0]};
    end
    a_neg = signed_op & a_ext[WIDTH-1];
    b_neg = signed_op & b_ext[WIDTH-1];
    // The negation of the most negative value gives 2^(WIDTH-1) read as unsigned.
    mag_a = a_neg ? -a_ext : a_ext;
    mag_b = b_neg ? -b_ext : b_ext;
  end

`ifdef SERIAL_DIVIDER_LZC_SKIP_EN
  logic [CNT_BITS:0] lzc;

  // Count the leading zeros of |dividend|. The highest set bit wins.
  always_comb begin
    lzc = (CNT_BITS+1)'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (mag_a[i]) lzc = (CNT_BITS+1)'(WIDTH - 1 - i);
    end
  end

  // Skip the leading zero dividend bits. The skip is not applied to a zero divisor.
  // A zero divisor runs every step so that the quotient comes out all ones.
  always_comb begin
    start_cnt = CNT_BITS'(WIDTH - 1);
    start_quo = mag_a;
    if (mag_b != '0) begin
      if (lzc == (CNT_BITS+1)'(WIDTH)) begin
        start_cnt = '0;
      end else begin
        start_cnt = CNT_BITS'(WIDTH - 1) - lzc[CNT_BITS-1:0];
        start_quo = mag_a << lzc;
      end
    end
  end
`else
  // Fixed schedule: every operation iterates over all WIDTH dividend bits.
  always_comb begin
    start_cnt = CNT_BITS'(WIDTH - 1);
    start_quo = mag_a;
  end
`endif

  // Do one restoring step: shift {rem,quo} left and subtract the divisor if it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, divisor_q};
    rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, divisor_q}) : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], rem_ge};
  end

  // Apply the sign fix and the W-op sign extension to the final quotient or remainder.
  always_comb begin
    quo_fix   = (quo_neg_q && !div_zero_q) ? -quo_q : quo_q;
    rem_fix   = rem_neg_q ? -rem_q : rem_q;
    res_sel   = quo_op_q ? quo_fix : rem_fix;
    res_final = w_op_q ? {{(WIDTH-W_BITS){res_sel[W_BITS-1]}}, res_sel[W_BITS-1:0]} : res_sel;
  end

  // Run the control FSM and the datapath registers. Flush takes priority over all other actions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the datapath registers are reset with the control state, so no X can reach result_o.
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      quo_op_q    <= 1'b0;
      w_op_q      <= 1'b0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      trans_q     <= '0;
      result_q    <= '0;
      trans_out_q <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else if (bus.flush_i) begin
      // NOTE: non-blocking assignments, so every register in this block samples pre-edge values.
      state_q <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.div_valid_i && is_div_op) begin
            quo_op_q   <= quo_op;
            w_op_q     <= w_op;
            quo_neg_q  <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div_zero_q <= (mag_b == '0);
            trans_q    <= bus.trans_id_i;
            divisor_q  <= mag_b;
            rem_q      <= '0;
            quo_q      <= start_quo;
            cnt_q      <= start_cnt;
            ready_q    <= 1'b0;
            state_q    <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          // The first FINISH cycle registers the result. The result then holds until writeback takes it.
          if (!valid_q) begin
            result_q    <= res_final;
            trans_out_q <= trans_q;
            valid_q     <= 1'b1;
          end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.div_ready_o    = ready_q;
  assign bus.div_valid_o    = valid_q;
  assign bus.result_o       = result_q;
  assign bus.div_trans_id_o = trans_out_q;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider.
// The stimulus process pushes the expected result, tag and latency of each accepted operation.
// A monitor process checks these against the DUT outputs.
// Expected results come from plain signed/unsigned arithmetic on the RV64M rules.

module tb_serial_divider;
  import serial_divider_pkg::*;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [2:0]  tid;
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  bit   valid_seen;
  logic [2:0] tid_next;
  exp_t sb_q[$];

  serial_divider_if #(.WIDTH(64), .TRANS_ID_BITS(3)) bus ();

  serial_divider #(.WIDTH(64), .TRANS_ID_BITS(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_w(input fu_op op);
    return op inside {DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic bit is_signed_op(input fu_op op);
    return op inside {DIV, REM, DIVW, REMW};
  endfunction

  // Reference result computed with the language's own division operators.
  function automatic logic [63:0] ref_result(input fu_op op, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] ua32, ub32, r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    r = '0; r32 = '0;
    case (op)
      DIV:   if (b == 0) r = '1; else if (a == MIN64 && sb == -1) r = a; else r = 64'(sa / sb);
      DIVU:  if (b == 0) r = '1; else r = a / b;
      REM:   if (b == 0) r = a; else if (a == MIN64 && sb == -1) r = '0; else r = 64'(sa % sb);
      REMU:  if (b == 0) r = a; else r = a % b;
      DIVW:  if (sb32 == 0) r32 = '1; else if (ua32 == 32'h8000_0000 && sb32 == -1) r32 = ua32;
             else r32 = 32'(sa32 / sb32);
      DIVUW: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
      REMW:  if (sb32 == 0) r32 = ua32; else if (ua32 == 32'h8000_0000 && sb32 == -1) r32 = '0;
             else r32 = 32'(sa32 % sb32);
      REMUW: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
      default: r = '0;
    endcase
    if (is_w(op)) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  // Cycles from the accept edge to the first div_valid_o.
  function automatic int exp_latency(input fu_op op, input logic [63:0] a, input logic [63:0] b);
`ifdef SERIAL_DIVIDER_LZC_SKIP_EN
    logic [63:0] ea, eb;
    int lz;
    ea = a; eb = b;
    if (is_w(op)) begin
      ea = is_signed_op(op) ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
      eb = is_signed_op(op) ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
    end
    if (is_signed_op(op) && ea[63]) ea = -ea;
    if (eb == 0) return 65;
    if (ea == 0) return 2;
    lz = 0;
    while (!ea[63]) begin ea = ea << 1; lz++; end
    return 65 - lz;
`else
    return 65 + 0 * int'(a[0] ^ b[0] ^ op[0]);
`endif
  endfunction

  // Check the first rise of div_valid_o for latency. Check each handshake for result and tag.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      valid_seen = 1'b0;
    end else begin
      if (bus.div_valid_o && !valid_seen) begin
        valid_seen = 1'b1;
        check("valid_has_pending", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check("latency", 64'(cyc - sb_q[0].acc), 64'(sb_q[0].lat));
      end
      if (bus.div_valid_o && bus.out_ready_i) begin
        valid_seen = 1'b0;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("result", bus.result_o, e.res);
          check("trans_id", 64'(bus.div_trans_id_o), 64'(e.tid));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.div_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(bus.div_ready_o), 64'd1);
  endtask

  task automatic issue(input fu_op op, input logic [63:0] a, input logic [63:0] b, input bit track);
    exp_t e;
    wait_ready();
    bus.div_valid_i = 1'b1;
    bus.operator_i  = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    bus.trans_id_i  = tid_next;
    @(posedge clk);
    #1;
    if (track) begin
      e.tid = tid_next;
      e.res = ref_result(op, a, b);
      e.acc = cyc;
      e.lat = exp_latency(op, a, b);
      sb_q.push_back(e);
    end
    tid_next        = tid_next + 3'd1;
    bus.div_valid_i = 1'b0;
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = MIN64;
      3:       v = {$urandom, $urandom};
      4:       v = 64'($urandom_range(0, 20));
      default: v = {{32{1'b1}}, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    fu_op ops[8];
    int   cnt;
    logic [63:0] exp_res;
    logic [2:0]  exp_tid;
    ops = '{DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
    checks = 0; failures = 0; cyc = 0; tid_next = 3'd1; valid_seen = 1'b0;
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.div_valid_i = 1'b0; bus.operator_i = ADD;
    bus.operand_a_i = '0; bus.operand_b_i = '0; bus.trans_id_i = '0; bus.out_ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.div_ready_o), 64'd1);
    check("reset_valid", 64'(bus.div_valid_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_trans_id", 64'(bus.div_trans_id_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    issue(DIVU,  64'd100, 64'd7, 1);
    issue(REM,   -64'sd7, 64'd2, 1);
    issue(DIV,   -64'sd7, 64'd2, 1);
    issue(DIV,   64'd5, 64'd0, 1);
    issue(REMU,  64'd5, 64'd0, 1);
    issue(REM,   -64'sd5, 64'd0, 1);
    issue(DIV,   MIN64, '1, 1);
    issue(REM,   MIN64, '1, 1);
    issue(DIVW,  64'h0000_0001_8000_0000, '1, 1);
    issue(REMUW, 64'h0000_0000_FFFF_FFFF, 64'h10, 1);
    issue(DIVU,  64'd3, 64'd1, 1);
    issue(DIVUW, 64'd0, 64'd0, 1);
    issue(REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1);

    // A non-divide operation is ignored.
    issue(ADD, 64'd9, 64'd3, 0);
    check("non_div_ignored_ready", 64'(bus.div_ready_o), 64'd1);

    // Backpressure: the result is held stable while out_ready_i is low.
    bus.out_ready_i = 1'b0;
    issue(DIVU, 64'd1000, 64'd33, 1);
    exp_res = sb_q[sb_q.size()-1].res;
    exp_tid = sb_q[sb_q.size()-1].tid;
    cnt = 0;
    while (!bus.div_valid_o && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(bus.div_valid_o), 64'd1);
      check("hold_result", bus.result_o, exp_res);
      check("hold_trans_id", 64'(bus.div_trans_id_o), 64'(exp_tid));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;

    // Flush in the 10th DIVIDE cycle drops the result.
    issue(DIVU, 64'd123456, 64'd7, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_ready", 64'(bus.div_ready_o), 64'd1);
    check("flush_valid", 64'(bus.div_valid_o), 64'd0);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.div_valid_o) cnt++;
    end
    check("flush_no_result", 64'(cnt), 64'd0);

    // Flush takes priority over a same-cycle accept.
    wait_ready();
    bus.flush_i = 1'b1; bus.div_valid_i = 1'b1; bus.operator_i = DIV;
    bus.operand_a_i = 64'd50; bus.operand_b_i = 64'd5;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0; bus.div_valid_i = 1'b0;
    check("flush_priority_ready", 64'(bus.div_ready_o), 64'd1);
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.div_valid_o) cnt++;
    end
    check("flush_priority_no_result", 64'(cnt), 64'd0);

    // A reset in the middle of an operation restores the reset values.
    issue(DIV, 64'd77777, 64'd13, 0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 64'(bus.div_ready_o), 64'd1);
    check("midreset_valid", 64'(bus.div_valid_o), 64'd0);
    check("midreset_result", bus.result_o, 64'd0);
    check("midreset_trans_id", 64'(bus.div_trans_id_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(0, 7)], rnd_operand(), rnd_operand(), 1);
    end

    wait_ready();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
